// File: rtl/morv_bus_responder.sv
// morv_bus_responder: word-organised RAM responder for the MoRV CPU bus.
// Each access completes after WAIT_STATES extra cycles with a one-cycle
// ready strobe. Byte-strobe writes go into the RAM window, and accesses
// outside the window are flagged with bus_err.
module morv_bus_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        write,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        bus_err,
    output logic [31:0] access_count
);

    localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_RELOAD   = 4'(WAIT_STATES);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [31:0] mem [DEPTH_WORDS];

    logic [0:0]       state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic             ready_next;
    logic [31:0]      rdata_next;
    logic             bus_err_next;
    logic [31:0]      count_next;
    logic             mem_we;

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] index;

    // Address decode against the RAM window.
    // A 33-bit compare avoids overflow when the window ends at 2^32.
    always_comb begin
        offset   = address - ADDR_BASE;
        in_range = (address >= ADDR_BASE) && ({1'b0, offset} < WINDOW_BYTES);
        index    = offset[IDX_W+1:2];
    end

    // Next-state and registered-output logic for the WAIT/RESP handshake.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ready_next   = 1'b0;
        rdata_next   = rdata;
        bus_err_next = bus_err;
        count_next   = access_count;
        mem_we       = 1'b0;
        case (state)
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next   = ST_RESP;
                    ready_next   = 1'b1;
                    rdata_next   = (in_range && !write) ? mem[index] : 32'd0;
                    bus_err_next = !in_range;
                end
            end
            ST_RESP: begin
                state_next = ST_WAIT;
                cnt_next   = CNT_RELOAD;
                count_next = access_count + 32'd1;
                mem_we     = in_range && write;
            end
            default: begin
                state_next = ST_WAIT;
                cnt_next   = CNT_RELOAD;
            end
        endcase
    end

    // State and output registers; reset wins over every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_WAIT;
            cnt          <= CNT_RELOAD;
            ready        <= 1'b0;
            rdata        <= 32'd0;
            bus_err      <= 1'b0;
            access_count <= 32'd0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            ready        <= ready_next;
            rdata        <= rdata_next;
            bus_err      <= bus_err_next;
            access_count <= count_next;
        end
    end

    // Byte-lane RAM write on the RESP closing edge. RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb[n]) begin
                    mem[index][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_morv_bus_responder.sv
// Directed testbench for morv_bus_responder.
// Covers reset values, reads, byte-strobe writes, out-of-range accesses,
// reset during a write response, and ready timing for several WAIT_STATES.
module tb_morv_bus_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WAIT_STATES=1, offset window)
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        write = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        bus_err;
    logic [31:0] access_count;

    morv_bus_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata), .write(write),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .bus_err(bus_err),
        .access_count(access_count)
    );

    // Latency-sweep DUTs sharing a constant read access
    logic        rst_s = 1'b1;
    logic [31:0] s_addr = 32'h0;
    logic [31:0] s_wdata = 32'h0;
    logic        s_write = 1'b0;
    logic [3:0]  s_wstrb = 4'h0;
    logic [31:0] rd0, rd3, rd15;
    logic        rdy0, rdy3, rdy15;
    logic        err0, err3, err15;
    logic [31:0] cnt0, cnt3, cnt15;

    morv_bus_responder #(.DEPTH_WORDS(4), .WAIT_STATES(0)) s0 (
        .clk(clk), .rst(rst_s), .address(s_addr), .wdata(s_wdata), .write(s_write),
        .wstrb(s_wstrb), .rdata(rd0), .ready(rdy0), .bus_err(err0), .access_count(cnt0)
    );
    morv_bus_responder #(.DEPTH_WORDS(4), .WAIT_STATES(3)) s3 (
        .clk(clk), .rst(rst_s), .address(s_addr), .wdata(s_wdata), .write(s_write),
        .wstrb(s_wstrb), .rdata(rd3), .ready(rdy3), .bus_err(err3), .access_count(cnt3)
    );
    morv_bus_responder #(.DEPTH_WORDS(4), .WAIT_STATES(15)) s15 (
        .clk(clk), .rst(rst_s), .address(s_addr), .wdata(s_wdata), .write(s_write),
        .wstrb(s_wstrb), .rdata(rd15), .ready(rdy15), .bus_err(err15), .access_count(cnt15)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus access on the main DUT, starting in the current cycle.
    // Checks that ready rises after exactly two cycles (WAIT_STATES+1).
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input string tag,
                          output logic [31:0] rd, output logic err);
        int lat;
        address = a;
        write   = w;
        wdata   = d;
        wstrb   = s;
        lat     = 0;
        while (!ready && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        rd  = rdata;
        err = bus_err;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          bad0, bad3, bad15;

        for (int i = 0; i < int'(DEPTH); i++) dut.mem[i] = 32'h0;
        dut.mem[0] = 32'hDEAD_BEEF;
        dut.mem[1] = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            s0.mem[i]  = 32'h0;
            s3.mem[i]  = 32'h0;
            s15.mem[i] = 32'h0;
        end

        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_count", access_count, 32'd0);
        rst = 1'b0;

        // First access: read mem[0] right after reset release
        access(BASE, 1'b0, 32'h0, 4'h0, "rd0", rd, err);
        chk("rd0_data", rd, 32'hDEAD_BEEF);
        chk("rd0_err", 32'(err), 32'd0);
        chk("rd0_count", access_count, 32'd1);

        // Byte-strobe write then readback
        access(BASE + 32'd8, 1'b1, 32'h1122_3344, 4'b0101, "wr2", rd, err);
        chk("wr2_rdata", rd, 32'd0);
        chk("wr2_err", 32'(err), 32'd0);
        access(BASE + 32'd8, 1'b0, 32'h0, 4'hF, "rd2", rd, err);
        chk("rd2_data", rd, 32'h0022_0044);

        // Write with no strobes leaves memory unchanged
        access(BASE + 32'd8, 1'b1, 32'hFFFF_FFFF, 4'b0000, "wr2z", rd, err);
        access(BASE + 32'd8, 1'b0, 32'h0, 4'h0, "rd2z", rd, err);
        chk("rd2z_data", rd, 32'h0022_0044);

        // Out-of-range read and write at the first address past the window
        access(BASE + 32'd64, 1'b0, 32'h0, 4'h0, "oor_rd", rd, err);
        chk("oor_rd_err", 32'(err), 32'd1);
        chk("oor_rd_data", rd, 32'd0);
        access(BASE + 32'd64, 1'b1, 32'hAAAA_5555, 4'hF, "oor_wr", rd, err);
        chk("oor_wr_err", 32'(err), 32'd1);
        access(BASE, 1'b0, 32'h0, 4'h0, "rd0b", rd, err);
        chk("rd0b_data", rd, 32'hDEAD_BEEF);

        // One word below the window
        access(BASE - 32'd4, 1'b0, 32'h0, 4'h0, "below", rd, err);
        chk("below_err", 32'(err), 32'd1);
        chk("below_data", rd, 32'd0);

        // Low address bits are ignored
        access(BASE + 32'd6, 1'b0, 32'h0, 4'h0, "rd1", rd, err);
        chk("rd1_data", rd, 32'h0BAD_F00D);
        chk("rd1_err", 32'(err), 32'd0);
        chk("count10", access_count, 32'd10);

        // Reset asserted during a write's RESP cycle
        address = BASE + 32'd12;
        write   = 1'b1;
        wdata   = 32'hFFFF_FFFF;
        wstrb   = 4'hF;
        lat     = 0;
        while (!ready && lat < 40) begin
            step();
            lat++;
        end
        chk("rstwr_latency", 32'(lat), 32'd2);
        rst = 1'b1;
        step();
        chk("rstwr_ready", 32'(ready), 32'd0);
        chk("rstwr_count", access_count, 32'd0);
        chk("rstwr_rdata", rdata, 32'd0);
        rst = 1'b0;
        access(BASE + 32'd12, 1'b0, 32'h0, 4'h0, "rd3", rd, err);
        chk("rd3_data", rd, 32'd0);
        chk("rd3_count", access_count, 32'd1);

        // Latency sweep: ready at cycles k*P + P-1 with P = WAIT_STATES+2
        rst_s = 1'b0;
        bad0  = 0;
        bad3  = 0;
        bad15 = 0;
        for (int c = 0; c <= 170; c++) begin
            if (c < 20 && rdy0 !== ((c % 2) == 1)) bad0++;
            if (c < 50 && rdy3 !== ((c % 5) == 4)) bad3++;
            if (c < 170 && rdy15 !== ((c % 17) == 16)) bad15++;
            if (c == 20)  chk("ws0_count", cnt0, 32'd10);
            if (c == 50)  chk("ws3_count", cnt3, 32'd10);
            if (c == 170) chk("ws15_count", cnt15, 32'd10);
            step();
        end
        chk("ws0_pattern_errs", 32'(bad0), 32'd0);
        chk("ws3_pattern_errs", 32'(bad3), 32'd0);
        chk("ws15_pattern_errs", 32'(bad15), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
